mult_result_scoreboard: RTL

- Downstream checker that consumes the Karatsuba multiplier's AXI-Stream Z output.
- Matches each Z beat in order against expected products, pushed into an internal FIFO when the corresponding operands are issued.
- Counts matches and errors per run of NUM_TESTS results and flags run pass/fail.
- Tolerates any multiplier latency up to DEPTH beats.

---
 rtl/mult_result_scoreboard.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mult_result_scoreboard.sv
// In-order checker for the Karatsuba multiplier Z stream: expected products are
// queued when operands issue and compared against each Z beat; run results are tallied.
module mult_result_scoreboard #(
    parameter int WIDTH     = 328,
    parameter int DEPTH     = 4,
    parameter int NUM_TESTS = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   exp_tvalid,
    input  logic [2*WIDTH-1:0]     exp_tdata,
    input  logic                   Z_tvalid,
    input  logic [2*WIDTH-1:0]     Z_tdata,
    output logic                   current_passed,
    output logic                   mismatch,
    output logic [CNT_WIDTH-1:0]   error_count,
    output logic [CNT_WIDTH-1:0]   match_count,
    output logic                   done,
    output logic                   all_passed,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int PW   = 2 * WIDTH;
    localparam int AW   = $clog2(DEPTH);
    localparam int PTRW = AW + 1;
    localparam int RW   = $clog2(NUM_TESTS) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [PW-1:0]         r_mem [DEPTH];
    logic [PTRW-1:0]       r_wr_ptr;
    logic [PTRW-1:0]       r_rd_ptr;
    logic [RW-1:0]         r_run_cnt;
    logic [CNT_WIDTH-1:0]  r_err_cnt;
    logic [CNT_WIDTH-1:0]  r_match_cnt;
    logic                  r_cur_passed;
    logic                  r_mismatch;
    logic                  r_all_passed;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_bypass;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_ovf;
    logic                  w_unf;
    logic [PW-1:0]         w_expected;
    logic                  w_match;
    logic                  w_fail;
    logic                  w_last;

    // Extra pointer MSB tells full from empty when the index bits coincide.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_bypass   = w_empty && exp_tvalid && Z_tvalid;
    assign w_pop      = Z_tvalid && !w_empty;
    assign w_push     = exp_tvalid && !w_bypass && (!w_full || w_pop);
    assign w_ovf      = exp_tvalid && w_full && !Z_tvalid;
    assign w_unf      = Z_tvalid && w_empty && !exp_tvalid;
    assign w_expected = w_bypass ? exp_tdata : r_mem[r_rd_ptr[AW-1:0]];
    assign w_match    = Z_tvalid && !w_unf && (Z_tdata == w_expected);
    assign w_fail     = Z_tvalid && !w_match;
    assign w_last     = Z_tvalid && (r_run_cnt == RW'(NUM_TESTS - 1));

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= exp_tdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTRW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTRW'(1);
            if (w_ovf)
                r_overflow <= 1'b1;
            if (w_unf)
                r_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (exp_tvalid) w_next = S_RUN;
            S_RUN:   if (w_last)     w_next = S_DONE;
            S_DONE:  w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        done = (r_state == S_DONE);
    end

    // The DONE cycle restarts the tallies, seeding them with any compare in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cnt   <= '0;
            r_err_cnt   <= '0;
            r_match_cnt <= '0;
        end else if (r_state == S_DONE) begin
            r_run_cnt   <= Z_tvalid ? RW'(1) : '0;
            r_err_cnt   <= w_fail  ? CNT_WIDTH'(1) : '0;
            r_match_cnt <= w_match ? CNT_WIDTH'(1) : '0;
        end else if (r_state == S_RUN && Z_tvalid) begin
            r_run_cnt <= r_run_cnt + RW'(1);
            if (w_fail && r_err_cnt != '1)
                r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
            if (w_match && r_match_cnt != '1)
                r_match_cnt <= r_match_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_passed <= 1'b0;
            r_mismatch   <= 1'b0;
            r_all_passed <= 1'b0;
        end else begin
            r_mismatch <= w_fail;
            if (Z_tvalid)
                r_cur_passed <= w_match;
            if (r_state == S_RUN && w_last)
                r_all_passed <= (r_err_cnt == '0) && !w_fail &&
                                !(r_overflow || w_ovf) && !(r_underflow || w_unf);
        end
    end

    assign current_passed = r_cur_passed;
    assign mismatch       = r_mismatch;
    assign error_count    = r_err_cnt;
    assign match_count    = r_match_cnt;
    assign all_passed     = r_all_passed;
    assign overflow       = r_overflow;
    assign underflow      = r_underflow;

endmodule
